// File: rtl/vliw_sequencer_multi.sv
// VLIW program sequencer: steps a program held in on-chip RAM one word per clock and drives
// N_LANES filter slices in lockstep, with one-shot / continuous modes and a clean stop.
module vliw_sequencer_multi #(
  parameter int unsigned N_LANES  = 2,
  parameter int unsigned PROG_AW  = 9,
  parameter int unsigned COEF_AW  = 9,
  parameter int unsigned STATE_AW = 4
) (
  input  logic                                          clock_200,
  input  logic                                          reset_n,
  input  logic                                          write_enable,
  input  logic [PROG_AW-1:0]                            write_address,
  input  logic [N_LANES*(COEF_AW+4*STATE_AW+2)-1:0]     write_data,
  input  logic [PROG_AW-1:0]                            prog_last,
  input  logic                                          continuous,
  input  logic                                          vliw_start,
  input  logic                                          vliw_stop,
  output logic                                          slice_enable,
  output logic [N_LANES*COEF_AW-1:0]                    lane_coef_rd,
  output logic [N_LANES*STATE_AW-1:0]                   lane_st_rd,
  output logic [N_LANES*STATE_AW-1:0]                   lane_st_wr,
  output logic [N_LANES*STATE_AW-1:0]                   lane_sd_rd,
  output logic [N_LANES*STATE_AW-1:0]                   lane_sd_wr,
  output logic [N_LANES-1:0]                            lane_log,
  output logic [N_LANES-1:0]                            lane_sd_store,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          write_err
);

  localparam int unsigned LANE_W = COEF_AW + 4 * STATE_AW + 2;
  localparam int unsigned WORD_W = N_LANES * LANE_W;
  localparam int unsigned DEPTH  = 2 ** PROG_AW;

  // StFlush holds the last instruction of a pass on the outputs before returning to idle.
  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e             state_q, state_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic [PROG_AW-1:0] last_q, last_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic               err_q, err_d;
  logic               en_q, en_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [WORD_W-1:0]  rd_data_q;
  logic [LANE_W-1:0]  lane;

  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      last_q  <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    err_d   = err_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    if (write_enable && (state_q != StIdle)) err_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (vliw_start) begin
          state_d = StRun;
          pc_d    = '0;
          last_d  = prog_last;
          cont_d  = continuous;
          err_d   = 1'b0;
          stop_d  = 1'b0;
        end
      end
      StRun: begin
        en_d = 1'b1;
        if (vliw_stop) stop_d = 1'b1;
        if (pc_q == last_q) begin
          // A stop seen on the final edge of a pass still ends the run after this pass.
          if (cont_q && !stop_q && !vliw_stop) pc_d = '0;
          else state_d = StFlush;
        end else begin
          pc_d = pc_q + PROG_AW'(1);
        end
      end
      StFlush: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_200) begin
    if (write_enable && (state_q == StIdle)) mem[write_address] <= write_data;
  end

  always_ff @(posedge clock_200) begin
    if (state_q == StRun) rd_data_q <= mem[pc_q];
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = done_q;
    write_err     = err_q;
    slice_enable  = en_q;
    lane          = '0;
    lane_coef_rd  = '0;
    lane_st_rd    = '0;
    lane_st_wr    = '0;
    lane_sd_rd    = '0;
    lane_sd_wr    = '0;
    lane_log      = '0;
    lane_sd_store = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane = en_q ? rd_data_q[i*LANE_W +: LANE_W] : '0;
      lane_coef_rd[i*COEF_AW +: COEF_AW]  = lane[0 +: COEF_AW];
      lane_st_rd[i*STATE_AW +: STATE_AW]  = lane[COEF_AW +: STATE_AW];
      lane_st_wr[i*STATE_AW +: STATE_AW]  = lane[COEF_AW + STATE_AW +: STATE_AW];
      lane_sd_rd[i*STATE_AW +: STATE_AW]  = lane[COEF_AW + 2*STATE_AW +: STATE_AW];
      lane_sd_wr[i*STATE_AW +: STATE_AW]  = lane[COEF_AW + 3*STATE_AW +: STATE_AW];
      lane_log[i]                         = lane[COEF_AW + 4*STATE_AW];
      lane_sd_store[i]                    = lane[COEF_AW + 4*STATE_AW + 1];
    end
  end

endmodule

// File: tb/tb_vliw_sequencer_multi.sv
// Bench for vliw_sequencer_multi: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a run/pass-level reference model.
module tb_vliw_sequencer_multi;

  localparam int N_LANES  = 2;
  localparam int PROG_AW  = 9;
  localparam int COEF_AW  = 9;
  localparam int STATE_AW = 4;
  localparam int LANE_W   = COEF_AW + 4 * STATE_AW + 2;
  localparam int WORD_W   = N_LANES * LANE_W;

  logic                          clock_200 = 1'b0;
  logic                          reset_n = 1'b1;
  logic                          write_enable = 1'b0;
  logic [PROG_AW-1:0]            write_address = '0;
  logic [WORD_W-1:0]             write_data = '0;
  logic [PROG_AW-1:0]            prog_last = '0;
  logic                          continuous = 1'b0;
  logic                          vliw_start = 1'b0;
  logic                          vliw_stop = 1'b0;
  logic                          slice_enable;
  logic [N_LANES*COEF_AW-1:0]    lane_coef_rd;
  logic [N_LANES*STATE_AW-1:0]   lane_st_rd, lane_st_wr, lane_sd_rd, lane_sd_wr;
  logic [N_LANES-1:0]            lane_log, lane_sd_store;
  logic                          busy, done, write_err;

  vliw_sequencer_multi #(
    .N_LANES (N_LANES),
    .PROG_AW (PROG_AW),
    .COEF_AW (COEF_AW),
    .STATE_AW(STATE_AW)
  ) dut (
    .clock_200    (clock_200),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .prog_last    (prog_last),
    .continuous   (continuous),
    .vliw_start   (vliw_start),
    .vliw_stop    (vliw_stop),
    .slice_enable (slice_enable),
    .lane_coef_rd (lane_coef_rd),
    .lane_st_rd   (lane_st_rd),
    .lane_st_wr   (lane_st_wr),
    .lane_sd_rd   (lane_sd_rd),
    .lane_sd_wr   (lane_sd_wr),
    .lane_log     (lane_log),
    .lane_sd_store(lane_sd_store),
    .busy         (busy),
    .done         (done),
    .write_err    (write_err)
  );

  always #5 clock_200 = ~clock_200;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock_200);
    #1;
  endtask

  function automatic logic [LANE_W-1:0] mk_lane(input int coef, input int st_rd, input int st_wr,
                                                 input int sd_rd, input int sd_wr,
                                                 input bit lg, input bit sds);
    return {sds, lg, STATE_AW'(sd_wr), STATE_AW'(sd_rd), STATE_AW'(st_wr), STATE_AW'(st_rd),
            COEF_AW'(coef)};
  endfunction

  // Reference model: a run is a sequence of passes over addresses 0..last, one word per cycle.
  logic [WORD_W-1:0] m_mem [0:(1<<PROG_AW)-1];
  bit                m_run, m_flush, m_cont, m_stop, was_busy;
  int                m_pc, m_last;
  bit                exp_en, exp_busy, exp_done, exp_err;
  logic [WORD_W-1:0] exp_word;

  always @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_flush = 0; m_pc = 0; m_stop = 0;
      exp_en = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
    end else begin
      was_busy = m_run || m_flush;
      if (write_enable) begin
        if (was_busy) exp_err = 1;
        else m_mem[write_address] = write_data;
      end
      exp_done = 0;
      if (m_flush) begin
        m_flush = 0; exp_en = 0; exp_done = 1;
      end else if (m_run) begin
        exp_en = 1;
        exp_word = m_mem[m_pc];
        if (vliw_stop) m_stop = 1;
        if (m_pc == m_last) begin
          if (m_cont && !m_stop) m_pc = 0;
          else begin m_run = 0; m_flush = 1; end
        end else m_pc++;
      end else if (vliw_start) begin
        m_run = 1; m_pc = 0; m_last = int'(prog_last); m_cont = continuous;
        exp_err = 0; m_stop = 0;
      end
      exp_busy = m_run || m_flush;
    end
  end

  bit                          chk_on = 0;
  logic [WORD_W-1:0]           w;
  logic [N_LANES*COEF_AW-1:0]  e_coef;
  logic [N_LANES*STATE_AW-1:0] e_st_rd, e_st_wr, e_sd_rd, e_sd_wr;
  logic [N_LANES-1:0]          e_log, e_sds;

  always @(negedge clock_200) begin
    if (chk_on) begin
      w = exp_en ? exp_word : '0;
      for (int i = 0; i < N_LANES; i++) begin
        e_coef[i*COEF_AW +: COEF_AW]  = w[i*LANE_W +: COEF_AW];
        e_st_rd[i*STATE_AW +: STATE_AW] = w[i*LANE_W + COEF_AW +: STATE_AW];
        e_st_wr[i*STATE_AW +: STATE_AW] = w[i*LANE_W + COEF_AW + STATE_AW +: STATE_AW];
        e_sd_rd[i*STATE_AW +: STATE_AW] = w[i*LANE_W + COEF_AW + 2*STATE_AW +: STATE_AW];
        e_sd_wr[i*STATE_AW +: STATE_AW] = w[i*LANE_W + COEF_AW + 3*STATE_AW +: STATE_AW];
        e_log[i] = w[i*LANE_W + COEF_AW + 4*STATE_AW];
        e_sds[i] = w[i*LANE_W + COEF_AW + 4*STATE_AW + 1];
      end
      check("cmp_enable", 64'(slice_enable), 64'(exp_en));
      check("cmp_coef", 64'(lane_coef_rd), 64'(e_coef));
      check("cmp_st_rd", 64'(lane_st_rd), 64'(e_st_rd));
      check("cmp_st_wr", 64'(lane_st_wr), 64'(e_st_wr));
      check("cmp_sd_rd", 64'(lane_sd_rd), 64'(e_sd_rd));
      check("cmp_sd_wr", 64'(lane_sd_wr), 64'(e_sd_wr));
      check("cmp_log", 64'(lane_log), 64'(e_log));
      check("cmp_sd_store", 64'(lane_sd_store), 64'(e_sds));
      check("cmp_busy", 64'(busy), 64'(exp_busy));
      check("cmp_done", 64'(done), 64'(exp_done));
      check("cmp_write_err", 64'(write_err), 64'(exp_err));
    end
  end

  // Observation log used by the literal checks.
  int          en_cnt = 0;
  int          done_cnt = 0;
  int          q_coef[$];
  logic [3:0]  q_trig[$];

  always @(negedge clock_200) begin
    if (reset_n) begin
      if (slice_enable) begin
        en_cnt++;
        q_coef.push_back(int'(lane_coef_rd[COEF_AW-1:0]));
        q_trig.push_back({lane_sd_store, lane_log});
      end
      if (done) done_cnt++;
    end
  end

  task automatic write_word(input int addr, input logic [WORD_W-1:0] data);
    write_enable = 1'b1;
    write_address = PROG_AW'(addr);
    write_data = data;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic start_run(input int last, input bit cont);
    prog_last = PROG_AW'(last);
    continuous = cont;
    q_coef.delete();
    q_trig.delete();
    vliw_start = 1'b1;
    tick();
    vliw_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check(name, 64'(busy), 64'(0));
  endtask

  function automatic logic [WORD_W-1:0] t2_word(input int n);
    bit hit;
    hit = (n == 0) || (n == 4) || (n == 6) || (n == 9);
    return {mk_lane(100 + n, 0, n, n % 16, 3, 1'b0, hit), mk_lane(n, n % 16, 15 - n, 0, 0, hit, 1'b0)};
  endfunction

  int e0, d0;
  bit hit;

  initial begin
    #1 reset_n = 1'b0;
    #1 chk_on = 1;
    repeat (3) tick();
    check("rst_enable", 64'(slice_enable), 64'(0));
    check("rst_coef", 64'(lane_coef_rd), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset_n = 1'b1;
    tick();
    check("rst_rel_busy", 64'(busy), 64'(0));
    check("rst_rel_err", 64'(write_err), 64'(0));

    // Ten-word one-shot run with distinct per-lane fields and triggers at 0, 4, 6, 9.
    for (int n = 0; n < 10; n++) write_word(n, t2_word(n));
    e0 = en_cnt; d0 = done_cnt;
    start_run(9, 1'b0);
    check("t2_latency", 64'(slice_enable), 64'(0));
    wait_idle("t2_timeout", 40);
    tick();
    check("t2_en_cycles", 64'(en_cnt - e0), 64'(10));
    check("t2_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t2_len", 64'(q_coef.size()), 64'(10));
    for (int i = 0; i < q_coef.size(); i++) begin
      hit = (i == 0) || (i == 4) || (i == 6) || (i == 9);
      check("t2_coef", 64'(q_coef[i]), 64'(i));
      check("t5_trig", 64'(q_trig[i]), hit ? 64'h9 : 64'h0);
    end

    // Write while busy is dropped and flags write_err until the next accepted start.
    start_run(9, 1'b0);
    tick(); tick();
    write_word(5, t2_word(77));
    wait_idle("t4_timeout", 40);
    check("t4_err_set", 64'(write_err), 64'(1));
    start_run(9, 1'b0);
    check("t4_err_clr", 64'(write_err), 64'(0));
    wait_idle("t4_timeout2", 40);
    check("t4_len", 64'(q_coef.size()), 64'(10));
    if (q_coef.size() > 5) check("t4_old_word", 64'(q_coef[5]), 64'(5));

    // Reset on the third instruction: outputs drop at once, no done pulse.
    start_run(9, 1'b0);
    tick(); tick(); tick();
    check("t6_third", 64'(lane_coef_rd[COEF_AW-1:0]), 64'(2));
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("t6_enable", 64'(slice_enable), 64'(0));
    check("t6_coef", 64'(lane_coef_rd), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'(0));
    start_run(9, 1'b0);
    wait_idle("t6_timeout", 40);
    check("t6_len", 64'(q_coef.size()), 64'(10));
    if (q_coef.size() > 0) check("t6_first", 64'(q_coef[0]), 64'(0));

    // Continuous four-word loop, stop raised on the first cycle of pass 3.
    for (int n = 0; n < 4; n++) write_word(n, {mk_lane(50 + n, 1, 2, 3, 4, 1'b0, 1'b0), mk_lane(20 + n, n, 0, 0, 0, 1'b0, 1'b0)});
    e0 = en_cnt; d0 = done_cnt;
    start_run(3, 1'b1);
    repeat (8) tick();
    vliw_stop = 1'b1;
    tick();
    vliw_stop = 1'b0;
    wait_idle("t3_timeout", 40);
    tick();
    check("t3_en_cycles", 64'(en_cnt - e0), 64'(12));
    check("t3_done_pulses", 64'(done_cnt - d0), 64'(1));
    for (int i = 0; i < q_coef.size(); i++) check("t3_coef", 64'(q_coef[i]), 64'(20 + i % 4));

    // Random traffic over a 16-word program space.
    for (int n = 10; n < 16; n++) write_word(n, WORD_W'({$urandom, $urandom}));
    for (int c = 0; c < 1500; c++) begin
      write_enable  = ($urandom_range(0, 5) == 0);
      write_address = PROG_AW'($urandom_range(0, 15));
      write_data    = WORD_W'({$urandom, $urandom});
      prog_last     = PROG_AW'($urandom_range(0, 15));
      continuous    = 1'($urandom_range(0, 1));
      vliw_start    = ($urandom_range(0, 4) == 0);
      vliw_stop     = ($urandom_range(0, 9) == 0);
      tick();
    end
    write_enable = 1'b0;
    vliw_start = 1'b0;
    vliw_stop = 1'b1;
    wait_idle("rand_timeout", 60);
    vliw_stop = 1'b0;
    tick();

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
